muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port req_valid  input  1  core presents an operation.
REQ-004 SHALL have port req_ready  output  1  unit accepts an operation this cycle.
REQ-005 SHALL have port funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port operandA  input  32  rs1 value; multiplicand or dividend.
REQ-007 SHALL have port operandB  input  32  rs2 value; multiplier or divisor.
REQ-008 SHALL have port resp_valid  output  1  result is available.
REQ-009 SHALL have port resp_ready  input  1  core consumes the result.
REQ-010 SHALL have port result  output  32  operation result.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 SHALL assert req_ready only in IDLE; a request is accepted on the edge where req_valid and req_ready are both high.
REQ-014 SHALL, on accept, register funct3 and both operands, and SHALL ignore input changes afterwards.
REQ-015 SHALL, for normal ops, go to BUSY and run a 6-bit counter through exactly 32 iterations, one per cycle: radix-2 shift-add for multiply, restoring divide for division.
REQ-016 SHALL enter DONE with resp_valid high on the 33rd rising edge after the accept edge.
REQ-017 SHALL hold resp_valid and result stable in DONE until resp_ready is high, then return to IDLE on that edge.
REQ-018 SHALL NOT accept a new request in the same cycle as a DONE response handshake; the minimum spacing between back-to-back ops is one IDLE cycle.
REQ-019 SHALL return the low 32 bits of the 64-bit product for MUL, and the high 32 bits for MULH (signed×signed), MULHSU (signed A × unsigned B) and MULHU (unsigned×unsigned).
REQ-020 SHALL, for signed ops, iterate on magnitudes and negate the result by sign. The quotient sign is the XOR of the operand signs; the remainder sign is the dividend sign.
REQ-021 SHALL handle divide-by-zero with a fast path: DIV/DIVU give 32'hFFFFFFFF, REM/REMU give operandA, and resp_valid is asserted on the edge after accept, skipping BUSY.
REQ-022 SHALL handle signed overflow (DIV/REM with A=32'h80000000, B=32'hFFFFFFFF) with a fast path: quotient 32'h80000000, remainder 0, 1-cycle latency.
REQ-023 SHALL drive result to 0 whenever resp_valid is low.

Reset
REQ-024 SHALL, while rst_n is low, force the state to IDLE, clear the counter and internal registers, and drive req_ready=1, resp_valid=0, result=0, busy=0.
REQ-025 SHALL, on reset mid-operation (BUSY or DONE), discard the operation with no response, and be ready on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL compile the divider datapath only when macro MULDIV_DIV_EN is defined.
REQ-027 SHALL, without MULDIV_DIV_EN, accept funct3[2]=1 requests and complete them in 1 cycle with result 0, with multiply behaviour unchanged.

Verification
REQ-028 SHALL cover: MUL A=7, B=-3 (32'hFFFFFFFD) -> result 32'hFFFFFFEB, resp_valid exactly 33 edges after accept.
REQ-029 SHALL cover: MULHU A=B=32'hFFFFFFFF -> 32'hFFFFFFFE; MULH same operands -> 0; MULHSU A=-1, B=2 -> 32'hFFFFFFFF.
REQ-030 SHALL cover: DIV A=-7, B=2 -> 32'hFFFFFFFD; REM same operands -> 32'hFFFFFFFF; DIVU A=100, B=7 -> 14.
REQ-031 SHALL cover: DIVU A=5, B=0 -> 32'hFFFFFFFF; REM A=5, B=0 -> 5; DIV A=32'h80000000, B=-1 -> 32'h80000000; each with resp_valid 1 edge after accept.
REQ-032 SHALL cover: resp_ready held low for 10 cycles in DONE -> result stable and req_ready low; then resp_ready=1 -> IDLE next edge.
REQ-033 SHALL cover: rst_n pulsed low at iteration 15 of a DIV -> outputs at reset values with no response; a new MUL 3×4 then returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; without it, divide ops complete in one cycle with result 0.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        fast_pend;
  logic [1:0]  op_q;
  logic        neg_q;
  logic [31:0] mag_q;
  logic [63:0] acc;
  logic [31:0] res_q;
`ifdef MULDIV_DIV_EN
  logic        is_div_q;
  logic        rneg_q;
  logic [32:0] rem_sh;
  logic [31:0] rem_sub;
`endif

  logic        accept;
  logic        a_sgn, b_sgn, a_neg, b_neg, fast;
  logic [31:0] a_mag, b_mag, fast_res;
  logic [32:0] mul_sum;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] res_fin;

  function automatic logic [63:0] apply_sign64(input logic [63:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [31:0] apply_sign32(input logic [31:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign accept = req_valid && req_ready;

  // Accept-time decode: operand signedness, magnitudes and the one-cycle fast paths
  always_comb begin
    if (funct3[2]) begin
      a_sgn = ~funct3[0];
      b_sgn = ~funct3[0];
    end else begin
      a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      b_sgn = (funct3[1:0] == 2'b01);
    end
    a_neg    = a_sgn && operandA[31];
    b_neg    = b_sgn && operandB[31];
    a_mag    = a_neg ? -operandA : operandA;
    b_mag    = b_neg ? -operandB : operandB;
    fast     = 1'b0;
    fast_res = 32'd0;
`ifdef MULDIV_DIV_EN
    if (funct3[2]) begin
      if (operandB == 32'd0) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? operandA : 32'hFFFF_FFFF;
      end else if (!funct3[0] && operandA == 32'h8000_0000 && operandB == 32'hFFFF_FFFF) begin
        fast     = 1'b1;
        fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
`else
    fast = funct3[2];
`endif
  end

  // One iteration step and final sign correction; acc holds {hi/rem, lo/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_q} : 33'd0);
    acc_step = {mul_sum, acc[31:1]};
    prod_fix = apply_sign64(acc, neg_q);
    res_fin  = (op_q == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef MULDIV_DIV_EN
    rem_sh  = {acc[63:32], acc[31]};
    rem_sub = rem_sh[31:0] - mag_q;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, mag_q})
        acc_step = {rem_sub, acc[30:0], 1'b1};
      else
        acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
      res_fin = op_q[1] ? apply_sign32(acc[63:32], rneg_q) : apply_sign32(acc[31:0], neg_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A fast-path op waits one cycle in IDLE (req_ready low) before DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fast_pend)            state_nxt = DONE;
        else if (accept && !fast) state_nxt = BUSY;
      end
      BUSY:    if (cnt == 6'd32) state_nxt = DONE;
      DONE:    if (resp_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && !fast_pend;
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    result     = resp_valid ? res_q : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 6'd0;
      fast_pend <= 1'b0;
      op_q      <= 2'd0;
      neg_q     <= 1'b0;
      mag_q     <= 32'd0;
      acc       <= 64'd0;
      res_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
      is_div_q  <= 1'b0;
      rneg_q    <= 1'b0;
`endif
    end else if (accept) begin
      op_q      <= funct3[1:0];
      neg_q     <= a_neg ^ b_neg;
      cnt       <= 6'd0;
      fast_pend <= fast;
      res_q     <= fast_res;
      mag_q     <= a_mag;
      acc       <= {32'd0, b_mag};
`ifdef MULDIV_DIV_EN
      is_div_q  <= funct3[2];
      rneg_q    <= a_neg;
      if (funct3[2]) begin
        mag_q <= b_mag;
        acc   <= {32'd0, a_mag};
      end
`endif
    end else if (state == IDLE && fast_pend) begin
      fast_pend <= 1'b0;
    end else if (state == BUSY) begin
      if (cnt == 6'd32) begin
        res_q <= res_fin;
      end else begin
        acc <= acc_step;
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; expectations follow MULDIV_DIV_EN the same way the design does.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .operandA(operandA), .operandB(operandB),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 3'b001 || f == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    if (!f[2]) return (f == 3'b000) ? p[31:0] : p[63:32];
`ifdef MULDIV_DIV_EN
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f[1:0])
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
`else
    return 32'd0;
`endif
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit fast_div;
    fast_div = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifndef MULDIV_DIV_EN
    fast_div = 1'b1;
`endif
    if (!f[2]) return 33;
    return fast_div ? 1 : 33;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output bit to);
    int n = 0;
    to = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      to = 1'b1;
      n_vec++;
      n_miss++;
      $display("FAIL issue: req_ready got %b after %0d cycles, required 1", req_ready, n);
      return;
    end
    req_valid = 1'b1;
    funct3    = f;
    operandA  = a;
    operandB  = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    funct3    = ~f;
    operandA  = $urandom;
    operandB  = $urandom;
  endtask

  task automatic await_resp(output logic [31:0] res, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    res = 32'd0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) begin
        to  = 1'b0;
        res = result;
        break;
      end
    end
    if (to) begin
      n_vec++;
      n_miss++;
      $display("FAIL await_resp: resp_valid got 0 for %0d edges, required 1", lat);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL reset req_ready: got %b, required 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL reset resp_valid: got %b, required 0", resp_valid); end
    n_vec++; if (result !== 32'd0) begin n_miss++; $display("FAIL reset result: got %h, required 0", result); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset busy: got %b, required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  tf[4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] ta[4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] tv[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [2:0]  f;
    logic [31:0] a, b, got;
    int          lat;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin f = tf[i]; a = ta[i]; b = tv[i]; end
      else begin f = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom; end
      e.res = model_res(f, a, b);
      e.lat = model_lat(f, a, b);
      sb.push_back(e);
      issue(f, a, b, to);
      if (!to) await_resp(got, lat, to);
      if (to) sb.delete();
      else begin
        e = sb.pop_front();
        n_vec++; if (got !== e.res) begin n_miss++; $display("FAIL mul[%0d] f=%0d result: got %h, required %h", i, f, got, e.res); end
        n_vec++; if (lat != e.lat) begin n_miss++; $display("FAIL mul[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
        consume();
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  tf[4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] tv[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [2:0]  f;
    logic [31:0] a, b, got;
    int          lat;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin f = tf[i]; a = ta[i]; b = tv[i]; end
      else begin
        f = 3'($urandom_range(4, 7));
        a = $urandom;
        b = (i == 7) ? 32'($urandom_range(1, 1000)) : $urandom;
        if (b == 32'd0) b = 32'd3;
      end
      e.res = model_res(f, a, b);
      e.lat = model_lat(f, a, b);
      sb.push_back(e);
      issue(f, a, b, to);
      if (!to) await_resp(got, lat, to);
      if (to) sb.delete();
      else begin
        e = sb.pop_front();
        n_vec++; if (got !== e.res) begin n_miss++; $display("FAIL div[%0d] f=%0d result: got %h, required %h", i, f, got, e.res); end
        n_vec++; if (lat != e.lat) begin n_miss++; $display("FAIL div[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
        consume();
      end
    end
  endtask

  task automatic test_fast_path();
    logic [2:0]  tf[5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b101};
    logic [31:0] ta[5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tv[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] got;
    int          lat;
    bit          to;
    exp_t        e;
    for (int i = 0; i < 5; i++) begin
      e.res = model_res(tf[i], ta[i], tv[i]);
      e.lat = model_lat(tf[i], ta[i], tv[i]);
      sb.push_back(e);
      issue(tf[i], ta[i], tv[i], to);
      if (!to) await_resp(got, lat, to);
      if (to) sb.delete();
      else begin
        e = sb.pop_front();
        n_vec++; if (got !== e.res) begin n_miss++; $display("FAIL fast[%0d] result: got %h, required %h", i, got, e.res); end
        n_vec++; if (lat != e.lat) begin n_miss++; $display("FAIL fast[%0d] latency: got %0d, required %0d", i, lat, e.lat); end
        consume();
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] got;
    int          lat;
    bit          to;
    exp_t        e;
    e.res = 32'd30;
    e.lat = 33;
    sb.push_back(e);
    issue(3'b000, 32'd5, 32'd6, to);
    if (!to) await_resp(got, lat, to);
    if (to) begin sb.delete(); return; end
    e = sb.pop_front();
    n_vec++; if (got !== e.res) begin n_miss++; $display("FAIL hold result: got %h, required %h", got, e.res); end
    // A competing request is held up during the stall and the handshake cycle
    req_valid = 1'b1; funct3 = 3'b000; operandA = 32'd9; operandB = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_vec++; if (result !== e.res) begin n_miss++; $display("FAIL hold[%0d] result: got %h, required %h", i, result, e.res); end
      n_vec++; if (resp_valid !== 1'b1) begin n_miss++; $display("FAIL hold[%0d] resp_valid: got %b, required 1", i, resp_valid); end
      n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL hold[%0d] req_ready: got %b, required 0", i, req_ready); end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL handshake busy: got %b, required 0", busy); end
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL handshake req_ready: got %b, required 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL handshake resp_valid: got %b, required 0", resp_valid); end
    n_vec++; if (result !== 32'd0) begin n_miss++; $display("FAIL handshake result: got %h, required 0", result); end
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL post-handshake busy: got %b, required 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  f;
    logic [31:0] got;
    int          lat;
    bit          to;
    bit          seen = 1'b0;
    exp_t        e;
`ifdef MULDIV_DIV_EN
    f = 3'b100;
`else
    f = 3'b011;
`endif
    e.res = model_res(f, 32'd1000, 32'd3);
    e.lat = model_lat(f, 32'd1000, 32'd3);
    sb.push_back(e);
    issue(f, 32'd1000, 32'd3, to);
    if (to) begin sb.delete(); return; end
    repeat (15) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL midop busy: got %b, required 1", busy); end
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL midrst req_ready: got %b, required 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL midrst resp_valid: got %b, required 0", resp_valid); end
    n_vec++; if (result !== 32'd0) begin n_miss++; $display("FAIL midrst result: got %h, required 0", result); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL midrst busy: got %b, required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid || !req_ready) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL postrst idle: response or not-ready seen %b, required 0", seen); end
    e.res = 32'd12;
    e.lat = 33;
    sb.push_back(e);
    issue(3'b000, 32'd3, 32'd4, to);
    if (!to) await_resp(got, lat, to);
    if (to) begin sb.delete(); return; end
    e = sb.pop_front();
    n_vec++; if (got !== e.res) begin n_miss++; $display("FAIL postrst mul result: got %h, required %h", got, e.res); end
    n_vec++; if (lat != e.lat) begin n_miss++; $display("FAIL postrst mul latency: got %0d, required %0d", lat, e.lat); end
    consume();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
